// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped byte cache controller.
package cache_pkg;

  localparam int unsigned AddrW         = 8;
  localparam int unsigned DataW         = 8;
  localparam int unsigned DefaultLines  = 4;
  localparam int unsigned DefaultMemWait = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StFill,
    StResp
  } state_e;

endpackage

// File: rtl/cache_array.sv
// Line storage: valid/dirty/tag/data with combinational read and one write port.
module cache_array
  import cache_pkg::*;
#(
  parameter int unsigned LINES = DefaultLines,
  parameter int unsigned IdxW  = $clog2(LINES),
  parameter int unsigned TagW  = AddrW - IdxW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IdxW-1:0]  idx_i,
  output logic             rd_valid_o,
  output logic             rd_dirty_o,
  output logic [TagW-1:0]  rd_tag_o,
  output logic [DataW-1:0] rd_data_o,
  input  logic             wr_en_i,
  input  logic [TagW-1:0]  wr_tag_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             wr_dirty_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TagW-1:0]  tag_q  [LINES];
  logic [DataW-1:0] data_q [LINES];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_data_o  = data_q[idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = wr_dirty_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[idx_i]  <= wr_tag_i;
      data_q[idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate byte cache controller (Moore FSM).
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned LINES    = DefaultLines,
  parameter int unsigned MEM_WAIT = DefaultMemWait
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AddrW-1:0] cpu_addr,
  input  logic [DataW-1:0] cpu_wdata,
  output logic [DataW-1:0] cpu_rdata,
  output logic             cpu_ready,
  output logic             MMRead,
  output logic             MMWrite,
  output logic [AddrW-1:0] ABUS,
  output logic [DataW-1:0] CachetoMem,
  output logic [AddrW-1:0] OldTag,
  output logic             CacheSwap,
  input  logic [DataW-1:0] MemtoCache
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = AddrW - IdxW;
  localparam int unsigned CntW = $clog2(MEM_WAIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_WAIT - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;

  logic [IdxW-1:0]  idx;
  logic [TagW-1:0]  tag;
  logic             rd_valid, rd_dirty, hit, arr_we;
  logic [TagW-1:0]  rd_tag;
  logic [DataW-1:0] rd_data, arr_wdata;

  assign idx = addr_q[IdxW-1:0];
  assign tag = addr_q[AddrW-1:IdxW];
  assign hit = rd_valid && (rd_tag == tag);
  // A read fill takes memory data; a write fill allocates with the CPU data.
  assign arr_wdata = (state_q == StFill && !we_q) ? MemtoCache : wdata_q;

  cache_array #(
    .LINES (LINES)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx_i      (idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (arr_we),
    .wr_tag_i   (tag),
    .wr_data_i  (arr_wdata),
    .wr_dirty_i (we_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    arr_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          state_d = StLookup;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end
      end
      StLookup: begin
        if (hit) begin
          state_d = StResp;
          arr_we  = we_q;
        end else if (rd_valid && rd_dirty) begin
          state_d = StWriteback;
        end else begin
          state_d = StFill;
        end
      end
      StWriteback: begin
        if (cnt_q == CntLast) state_d = StFill;
        else                  cnt_d = cnt_q + CntW'(1);
      end
      StFill: begin
        if (cnt_q == CntLast) begin
          state_d = StResp;
          arr_we  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs depend only on registered state, so reset clears them without an edge.
  assign cpu_ready  = (state_q == StResp);
  assign cpu_rdata  = (state_q == StResp) ? rd_data : '0;
  assign MMRead     = (state_q == StFill);
  assign MMWrite    = (state_q == StWriteback);
  assign CacheSwap  = (state_q == StWriteback);
  assign OldTag     = (state_q == StWriteback) ? {rd_tag, idx} : '0;
  assign CachetoMem = (state_q == StWriteback) ? rd_data : '0;
  assign ABUS       = addr_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl against a line-level reference model.
module tb_cache_ctrl;

  localparam int MW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_ready, mm_read, mm_write, cache_swap;
  logic [7:0] abus, cache_to_mem, old_tag, mem_to_cache;

  int total = 0;
  int bad   = 0;

  // Main memory and reference cache state
  logic [7:0] mem [256];
  logic       m_valid [4];
  logic       m_dirty [4];
  logic [5:0] m_tag   [4];
  logic [7:0] m_data  [4];

  assign mem_to_cache = mem[abus];

  always #5 clk = ~clk;

  cache_ctrl #(
    .LINES    (4),
    .MEM_WAIT (MW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .MMRead     (mm_read),
    .MMWrite    (mm_write),
    .ABUS       (abus),
    .CachetoMem (cache_to_mem),
    .OldTag     (old_tag),
    .CacheSwap  (cache_swap),
    .MemtoCache (mem_to_cache)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Runs one CPU access; expectations come from the model state before the access.
  task automatic access(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    int         idx, n, nr, nw, exp_lat, exp_nr, exp_nw;
    logic [5:0] tg;
    logic       hit, dirty_miss, done;
    logic [7:0] wb_addr, wb_data, exp_rd;
    idx        = int'(addr[1:0]);
    tg         = addr[7:2];
    hit        = m_valid[idx] && (m_tag[idx] == tg);
    dirty_miss = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr    = {m_tag[idx], addr[1:0]};
    wb_data    = m_data[idx];
    exp_nw     = dirty_miss ? MW : 0;
    exp_nr     = hit ? 0 : MW;
    exp_lat    = 2 + exp_nr + exp_nw;
    if (hit) begin
      if (we) begin
        m_data[idx]  = wd;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = we ? wd : mem[addr];
      m_dirty[idx] = we;
    end
    exp_rd = m_data[idx];

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    n = 0; nr = 0; nw = 0; done = 1'b0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
      check("strobe_overlap", {31'b0, mm_read & mm_write}, 0);
      if (mm_read) begin
        nr++;
        check("abus", {24'b0, abus}, {24'b0, addr});
      end
      if (mm_write) begin
        nw++;
        check("cache_swap", {31'b0, cache_swap}, 1);
        check("old_tag", {24'b0, old_tag}, {24'b0, wb_addr});
        check("cache_to_mem", {24'b0, cache_to_mem}, {24'b0, wb_data});
      end else begin
        check("swap_idle", {31'b0, cache_swap}, 0);
      end
      if (cpu_ready) begin
        done = 1'b1;
        check("latency", n, exp_lat);
        check("rdata", {24'b0, cpu_rdata}, {24'b0, exp_rd});
        cpu_req = 1'b0;
      end
    end
    if (!done) begin
      check("ready_timeout", 0, 1);
      cpu_req = 1'b0;
    end
    check("mmread_cycles", nr, exp_nr);
    check("mmwrite_cycles", nw, exp_nw);
    if (dirty_miss) mem[wb_addr] = wb_data;
    // Idle gap keeps the RESP cycle from overlapping the next request.
    @(negedge clk);
    check("ready_pulse", {31'b0, cpu_ready}, 0);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h15] = 8'hA5;
    model_clear();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #1;
    check("rst_ready", {31'b0, cpu_ready}, 0);
    check("rst_rdata", {24'b0, cpu_rdata}, 0);
    check("rst_strobes", {30'b0, mm_read, mm_write}, 0);
    check("rst_abus", {24'b0, abus}, 0);
    check("rst_oldtag", {24'b0, old_tag}, 0);
    check("rst_c2m", {24'b0, cache_to_mem}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b0, 8'h15, 8'h00);  // cold read miss
    access(1'b0, 8'h15, 8'h00);  // read hit
    access(1'b1, 8'h15, 8'h3C);  // write hit, dirties line 1
    access(1'b0, 8'h25, 8'h00);  // dirty miss: writes back 0x15/0x3C
    check("mem_wb_15", {24'b0, mem[8'h15]}, 32'h3C);
    access(1'b1, 8'h40, 8'h77);  // write-allocate miss
    access(1'b0, 8'h80, 8'h00);  // writes back 0x40/0x77
    check("mem_wb_40", {24'b0, mem[8'h40]}, 32'h77);

    for (int k = 0; k < 150; k++) begin
      access(1'($urandom), {4'b0, 4'($urandom)}, 8'($urandom));
    end

    // Reset in the middle of a fill
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'hC6; cpu_wdata = '0;
    if (m_valid[2] && m_tag[2] == 6'h31) access(1'b0, 8'h06, 8'h00);
    cpu_req = 1'b1; cpu_addr = 8'hC6;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mm_read) seen = 1'b1;
    end
    check("fill_seen", {31'b0, seen}, 1);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("rst_mid_mmread", {31'b0, mm_read}, 0);
    check("rst_mid_ready", {31'b0, cpu_ready}, 0);
    check("rst_mid_abus", {24'b0, abus}, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_ready_after_rst", {31'b0, cpu_ready}, 0);
    end
    access(1'b0, 8'hC6, 8'h00);  // must miss again after reset
    access(1'b0, 8'h15, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
